// File: rtl/core_exc_entry.sv
// Exception-entry sequencer: arbitrates pending exceptions, switches mode, saves SPSR, writes LR, branches to vector.
// Latency: exc_ack in the accept cycle, then SET_MODE, SAVE_SPSR, BRANCH; minimum 3 cycles after accept.
// Backpressure: BRANCH holds branch/vector until branch_ready; requests arriving while busy are ignored.
module core_exc_entry #(
    parameter bit HIGH_VECTORS = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        boundary,
    input  logic        irq,
    input  logic        fiq,
    input  logic        dabt,
    input  logic        pabt,
    input  logic        undef,
    input  logic        swi,
    input  logic [31:0] fault_pc,
    input  logic [31:0] cpsr_rd,
    input  logic        mask_i,
    input  logic        mask_f,
    output logic        psr_write,
    output logic        psr_saved,
    output logic        psr_wr_flags,
    output logic        psr_wr_control,
    output logic        psr_force,
    output logic [31:0] psr_wr,
    output logic        lr_write,
    output logic [31:0] lr_data,
    output logic        branch,
    output logic [31:0] vector,
    input  logic        branch_ready,
    output logic        exc_ack,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, SET_MODE, SAVE_SPSR, BRANCH} state_t;
    typedef enum logic [2:0] {K_DABT, K_FIQ, K_IRQ, K_PABT, K_UNDEF, K_SWI} kind_t;

    localparam logic [31:0] VEC_BASE = HIGH_VECTORS ? 32'hFFFF_0000 : 32'h0000_0000;

    state_t      state_q, state_n;
    kind_t       kind_q, kind_n;
    logic [31:0] cpsr_q;
    logic [31:0] pc_q;
    logic        mask_f_q;

    logic        fiq_ok, irq_ok, any_req, accept;

    // Attributes of the latched exception kind
    logic [31:0] vec_off;
    logic [4:0]  new_mode;
    logic [31:0] lr_off;
    logic        f_set;

    // Interrupts are gated by the masks seen in the accept cycle; sync requests are always eligible
    assign fiq_ok  = fiq & ~mask_f;
    assign irq_ok  = irq & ~mask_i;
    assign any_req = dabt | fiq_ok | irq_ok | pabt | undef | swi;
    assign accept  = (state_q == IDLE) & boundary & any_req & ~rst;

    // Fixed-priority winner selection: dabt > fiq > irq > pabt > undef > swi
    always_comb begin
        kind_n = K_SWI;
        if (dabt)        kind_n = K_DABT;
        else if (fiq_ok) kind_n = K_FIQ;
        else if (irq_ok) kind_n = K_IRQ;
        else if (pabt)   kind_n = K_PABT;
        else if (undef)  kind_n = K_UNDEF;
    end

    // Decode vector offset, target mode, LR offset and F handling for the latched kind
    always_comb begin
        vec_off  = 32'h0000_0008;
        new_mode = 5'b10011;
        lr_off   = 32'd4;
        f_set    = 1'b0;
        case (kind_q)
            K_DABT:  begin vec_off = 32'h10; new_mode = 5'b10111; lr_off = 32'd8; end
            K_FIQ:   begin vec_off = 32'h1C; new_mode = 5'b10001; f_set = 1'b1; end
            K_IRQ:   begin vec_off = 32'h18; new_mode = 5'b10010; end
            K_PABT:  begin vec_off = 32'h0C; new_mode = 5'b10111; end
            K_UNDEF: begin vec_off = 32'h04; new_mode = 5'b11011; end
            default: begin vec_off = 32'h08; new_mode = 5'b10011; end
        endcase
    end

    // State register and request latches; reset aborts any sequence in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            kind_q   <= K_DABT;
            cpsr_q   <= 32'h0;
            pc_q     <= 32'h0;
            mask_f_q <= 1'b0;
        end else begin
            state_q <= state_n;
            if (accept) begin
                kind_q   <= kind_n;
                cpsr_q   <= cpsr_rd;
                pc_q     <= fault_pc;
                mask_f_q <= mask_f;
            end
        end
    end

    // Next state and outputs; everything except exc_ack derives only from state and latches
    always_comb begin
        state_n        = state_q;
        exc_ack        = accept;
        busy           = (state_q != IDLE);
        psr_write      = 1'b0;
        psr_saved      = 1'b0;
        psr_wr_flags   = 1'b0;
        psr_wr_control = 1'b0;
        psr_force      = 1'b0;
        psr_wr         = 32'h0;
        lr_write       = 1'b0;
        lr_data        = 32'h0;
        branch         = 1'b0;
        vector         = 32'h0;
        case (state_q)
            IDLE: begin
                if (accept) state_n = SET_MODE;
            end
            SET_MODE: begin
                psr_write      = 1'b1;
                psr_wr_control = 1'b1;
                psr_force      = 1'b1;
                // A=1, I=1, F per kind, T=0, M=new mode
                psr_wr         = {cpsr_q[31:9], 1'b1, 1'b1, (f_set | mask_f_q), 1'b0, new_mode};
                state_n        = SAVE_SPSR;
            end
            SAVE_SPSR: begin
                psr_write      = 1'b1;
                psr_saved      = 1'b1;
                psr_wr_flags   = 1'b1;
                psr_wr_control = 1'b1;
                psr_wr         = cpsr_q;
                lr_write       = 1'b1;
                lr_data        = pc_q + lr_off;
                state_n        = BRANCH;
            end
            BRANCH: begin
                branch = 1'b1;
                vector = VEC_BASE | vec_off;
                if (branch_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_core_exc_entry.sv
// Scoreboard bench for core_exc_entry: low-vector and high-vector instances share stimulus.
// Expected per-cycle output records are queued with their cycle number; a negedge monitor pops on activity.
// Directed sequences cover priority, masking, back-to-back entry, branch stall and mid-sequence reset.
module tb_core_exc_entry;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        boundary = 1'b0;
    logic        irq = 1'b0, fiq = 1'b0, dabt = 1'b0, pabt = 1'b0, undef = 1'b0, swi = 1'b0;
    logic [31:0] fault_pc = 32'h0;
    logic [31:0] cpsr_rd = 32'h0;
    logic        mask_i = 1'b0, mask_f = 1'b0;
    logic        branch_ready = 1'b1;

    logic        a_pw, a_ps, a_pf, a_pc, a_pfo, a_lw, a_br, a_ack, a_busy;
    logic [31:0] a_pwd, a_ld, a_vec;
    logic        b_pw, b_ps, b_pf, b_pc, b_pfo, b_lw, b_br, b_ack, b_busy;
    logic [31:0] b_pwd, b_ld, b_vec;

    always #5 clk = ~clk;

    core_exc_entry #(.HIGH_VECTORS(1'b0)) dut_lo (
        .clk(clk), .rst(rst), .boundary(boundary),
        .irq(irq), .fiq(fiq), .dabt(dabt), .pabt(pabt), .undef(undef), .swi(swi),
        .fault_pc(fault_pc), .cpsr_rd(cpsr_rd), .mask_i(mask_i), .mask_f(mask_f),
        .psr_write(a_pw), .psr_saved(a_ps), .psr_wr_flags(a_pf), .psr_wr_control(a_pc),
        .psr_force(a_pfo), .psr_wr(a_pwd), .lr_write(a_lw), .lr_data(a_ld),
        .branch(a_br), .vector(a_vec), .branch_ready(branch_ready),
        .exc_ack(a_ack), .busy(a_busy)
    );

    core_exc_entry #(.HIGH_VECTORS(1'b1)) dut_hi (
        .clk(clk), .rst(rst), .boundary(boundary),
        .irq(irq), .fiq(fiq), .dabt(dabt), .pabt(pabt), .undef(undef), .swi(swi),
        .fault_pc(fault_pc), .cpsr_rd(cpsr_rd), .mask_i(mask_i), .mask_f(mask_f),
        .psr_write(b_pw), .psr_saved(b_ps), .psr_wr_flags(b_pf), .psr_wr_control(b_pc),
        .psr_force(b_pfo), .psr_wr(b_pwd), .lr_write(b_lw), .lr_data(b_ld),
        .branch(b_br), .vector(b_vec), .branch_ready(branch_ready),
        .exc_ack(b_ack), .busy(b_busy)
    );

    typedef struct packed {
        logic        ack;
        logic        pw, ps, pf, pc, pfo;
        logic [31:0] pwd;
        logic        lw;
        logic [31:0] ld;
        logic        br;
        logic [31:0] vec;
        logic        busy;
    } obs_t;

    typedef struct {
        int   cyc;
        obs_t o;
    } exp_t;

    exp_t q[$];
    int   cyc_cnt = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic obs_t mk(input logic ack, pw, ps, pf, pc, pfo, input logic [31:0] pwd,
                                input logic lw, input logic [31:0] ld, input logic br,
                                input logic [31:0] vec, input logic busy);
        obs_t o;
        o.ack = ack; o.pw = pw; o.ps = ps; o.pf = pf; o.pc = pc; o.pfo = pfo; o.pwd = pwd;
        o.lw = lw; o.ld = ld; o.br = br; o.vec = vec; o.busy = busy;
        return o;
    endfunction

    task automatic push(input int c, input obs_t o);
        exp_t e;
        e.cyc = c;
        e.o   = o;
        q.push_back(e);
    endtask

    // Queue the per-cycle records of one entry sequence accepted in cycle t0.
    // stall = cycles with branch_ready low in BRANCH; -1 means the sequence is cut by reset after SAVE_SPSR.
    task automatic expect_entry(input int t0, input logic [31:0] set_w, saved_w, lr, vec_off, input int stall);
        push(t0,     mk(1, 0, 0, 0, 0, 0, 32'h0,   0, 32'h0, 0, 32'h0, 0));
        push(t0 + 1, mk(0, 1, 0, 0, 1, 1, set_w,   0, 32'h0, 0, 32'h0, 1));
        push(t0 + 2, mk(0, 1, 1, 1, 1, 0, saved_w, 1, lr,    0, 32'h0, 1));
        for (int i = 0; i <= stall; i++)
            push(t0 + 3 + i, mk(0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 1, vec_off, 1));
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc_cnt, got, exp);
        end
    endtask

    // Monitor: any output activity on either instance must match the next queued record
    always @(negedge clk) begin
        obs_t oa, ob, ea, eb;
        exp_t e;
        oa = mk(a_ack, a_pw, a_ps, a_pf, a_pc, a_pfo, a_pwd, a_lw, a_ld, a_br, a_vec, a_busy);
        ob = mk(b_ack, b_pw, b_ps, b_pf, b_pc, b_pfo, b_pwd, b_lw, b_ld, b_br, b_vec, b_busy);
        if ((a_ack | a_pw | a_lw | a_br | b_ack | b_pw | b_lw | b_br) === 1'b1) begin
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_output cyc=%0d got_lo=%h got_hi=%h expected=none", cyc_cnt, oa, ob);
            end else begin
                e  = q.pop_front();
                ea = e.o;
                eb = e.o;
                if (eb.br) eb.vec = eb.vec | 32'hFFFF_0000;
                if (e.cyc != cyc_cnt || oa !== ea || ob !== eb) begin
                    miscompares++;
                    $display("FAIL seq_record cyc=%0d exp_cyc=%0d got_lo=%h exp_lo=%h got_hi=%h exp_hi=%h",
                             cyc_cnt, e.cyc, oa, ea, ob, eb);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("quiet_ack", {31'h0, a_ack}, 32'h0);
            chk("quiet_busy", {31'h0, a_busy}, 32'h0);
            @(posedge clk);
            #1;
        end
    endtask

    int t0;

    initial begin
        // Reset state
        repeat (2) cyc();
        chk("rst_busy", {31'h0, a_busy}, 32'h0);
        chk("rst_psr_write", {31'h0, a_pw}, 32'h0);
        chk("rst_branch", {31'h0, b_br}, 32'h0);
        chk("rst_lr_write", {31'h0, a_lw}, 32'h0);
        rst = 1'b0;
        cyc();

        // IRQ from SYS mode
        cpsr_rd = 32'h6000_001F; fault_pc = 32'h100; boundary = 1'b1; irq = 1'b1;
        expect_entry(cyc_cnt, 32'h6000_0192, 32'h6000_001F, 32'h104, 32'h18, 0);
        cyc(); irq = 1'b0;
        repeat (3) cyc();

        // dabt beats fiq; fiq stays pending and is taken back-to-back
        dabt = 1'b1; fiq = 1'b1; fault_pc = 32'h2000;
        t0 = cyc_cnt;
        expect_entry(t0,     32'h6000_0197, 32'h6000_001F, 32'h2008, 32'h10, 0);
        expect_entry(t0 + 4, 32'h6000_01D1, 32'h6000_0197, 32'h3004, 32'h1C, 0);
        cyc(); dabt = 1'b0; cpsr_rd = 32'h6000_0197; fault_pc = 32'h3000;
        repeat (3) cyc();
        cyc(); fiq = 1'b0; cpsr_rd = 32'h6000_001F;
        repeat (4) cyc();

        // Masked irq, then unmasked irq without a boundary
        irq = 1'b1; mask_i = 1'b1;
        quiet(5);
        mask_i = 1'b0; boundary = 1'b0;
        quiet(5);
        irq = 1'b0; boundary = 1'b1;

        // undef from USR
        cpsr_rd = 32'h0000_0010; fault_pc = 32'h400; undef = 1'b1;
        expect_entry(cyc_cnt, 32'h0000_019B, 32'h0000_0010, 32'h404, 32'h04, 0);
        cyc(); undef = 1'b0;
        repeat (4) cyc();

        // swi with a 5-cycle branch stall; irq raised during the stall waits for IDLE
        cpsr_rd = 32'h6000_001F; fault_pc = 32'h500; swi = 1'b1;
        t0 = cyc_cnt;
        expect_entry(t0,     32'h6000_0193, 32'h6000_001F, 32'h504, 32'h08, 5);
        expect_entry(t0 + 9, 32'h6000_0192, 32'h6000_001F, 32'h604, 32'h18, 0);
        cyc(); swi = 1'b0;
        cyc(); branch_ready = 1'b0;
        cyc();
        cyc(); irq = 1'b1; fault_pc = 32'h600;
        repeat (4) cyc();
        branch_ready = 1'b1;
        cyc();
        cyc(); irq = 1'b0;
        repeat (3) cyc();

        // Reset during SAVE_SPSR aborts before BRANCH
        fault_pc = 32'h700; irq = 1'b1;
        expect_entry(cyc_cnt, 32'h6000_0192, 32'h6000_001F, 32'h704, 32'h18, -1);
        cyc(); irq = 1'b0;
        cyc(); rst = 1'b1;
        cyc(); rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'h0, a_busy}, 32'h0);
        chk("abort_busy_hi", {31'h0, b_busy}, 32'h0);
        chk("abort_psr_write", {31'h0, a_pw}, 32'h0);
        chk("abort_psr_wr", a_pwd, 32'h0);
        chk("abort_lr_write", {31'h0, a_lw}, 32'h0);
        chk("abort_branch", {31'h0, a_br}, 32'h0);
        repeat (4) cyc();

        chk("queue_drained", q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
